// File: rtl/uart_rx_8n1_pkg.sv
// uart_rx_8n1_pkg: receiver state encoding and bit-period constants
// (clock cycles per bit at a 50 MHz system clock).
package uart_rx_8n1_pkg;
    localparam int B9600   = 5208;
    localparam int B19200  = 2604;
    localparam int B57600  = 868;
    localparam int B115200 = 434;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO; a full FIFO still accepts
// a push when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? 8'h00 : mem[rd_ptr];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 serial receiver with mid-bit sampling, frame-error pulse,
// break recovery and a receive FIFO with a sticky overrun flag.
module uart_rx_8n1
    import uart_rx_8n1_pkg::*;
#(
    parameter int BAUDRATE   = B9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_rx_serial,
    output logic [7:0]                    o_rx_data,
    output logic                          o_rx_data_valid,
    input  logic                          i_rx_data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_frame_error,
    output logic                          o_overrun,
    input  logic                          i_clear_overrun
);
    localparam int TW = $clog2(BAUDRATE);
    localparam logic [TW-1:0] HALF = TW'(BAUDRATE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(BAUDRATE - 1);
    rx_state_t state;
    logic sync1, sync2, prev;
    logic [TW-1:0] timer;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic push, pop, full, empty;
    assign push            = state == STOP && timer == LAST && sync2;
    assign o_rx_data_valid = !empty;
    assign pop             = o_rx_data_valid && i_rx_data_ready;
    // prev is only an edge detector on the already synchronised line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            prev          <= 1'b1;
            state         <= IDLE;
            timer         <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            o_frame_error <= 1'b0;
        end else begin
            sync1         <= i_rx_serial;
            sync2         <= sync1;
            prev          <= sync2;
            o_frame_error <= 1'b0;
            timer         <= timer + 1'b1;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (prev && !sync2) state <= START;
                end
                START: if (timer == HALF) begin
                    timer   <= '0;
                    bit_idx <= '0;
                    state   <= sync2 ? IDLE : DATA;
                end
                DATA: if (timer == LAST) begin
                    timer   <= '0;
                    shift   <= {sync2, shift[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= STOP;
                end
                STOP: if (timer == LAST) begin
                    timer         <= '0;
                    o_frame_error <= !sync2;
                    state         <= sync2 ? IDLE : WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    timer <= '0;
                    if (sync2) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) o_overrun <= 1'b0;
        else if (push && full && !pop) o_overrun <= 1'b1;
        else if (i_clear_overrun) o_overrun <= 1'b0;
    end
    uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift),
        .pop       (pop),
        .head      (o_rx_data),
        .full      (full),
        .empty     (empty),
        .count     (o_fifo_count)
    );
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed scenarios plus random frames, checked every cycle
// against a queue model of the receive FIFO.
module tb_uart_rx_8n1;
    localparam int B = 16;
    localparam int D = 8;
    // Edges from the line falling to the stop-bit sample: 2 sync + 1 detect,
    // half a bit to mid-start, then nine full bits to mid-stop.
    localparam int STOP_LAT = 3 + B / 2 + 9 * B;

    logic clk = 0, reset = 1, rx_line = 1, ready = 0, clr = 0;
    logic [7:0] data;
    logic valid, fe, ovr;
    logic [3:0] count;

    uart_rx_8n1 #(.BAUDRATE(B), .FIFO_DEPTH(D)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_rx_serial     (rx_line),
        .o_rx_data       (data),
        .o_rx_data_valid (valid),
        .i_rx_data_ready (ready),
        .o_fifo_count    (count),
        .o_frame_error   (fe),
        .o_overrun       (ovr),
        .i_clear_overrun (clr)
    );

    always #5 clk = ~clk;

    typedef struct { int e; logic [7:0] b; bit good; } frame_t;
    frame_t pending[$];
    logic [7:0] q[$];
    bit m_ovr = 0, m_fe = 0;
    int cyc = 0, checks = 0, fails = 0, fe_seen = 0;
    logic rdy_q = 0, clr_q = 0, rst_q = 1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_q <= ready;
        clr_q <= clr;
        rst_q <= reset;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        bit pop, drop;
        frame_t f;
        if (reset || rst_q) begin
            q.delete();
            pending.delete();
            m_ovr = 0;
            m_fe = 0;
        end else begin
            pop = rdy_q && q.size() > 0;
            drop = 0;
            m_fe = 0;
            if (pop) void'(q.pop_front());
            if (pending.size() > 0 && pending[0].e == cyc) begin
                f = pending.pop_front();
                if (!f.good) m_fe = 1;
                else if (q.size() < D) q.push_back(f.b);
                else drop = 1;
            end
            if (drop) m_ovr = 1;
            else if (clr_q) m_ovr = 0;
        end
        check("valid", valid, q.size() > 0);
        check("data", data, q.size() > 0 ? q[0] : 8'h00);
        check("count", count, q.size());
        check("frame_error", fe, m_fe);
        check("overrun", ovr, m_ovr);
        if (fe) fe_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b, input bit stop = 1, input int tail_low = 0);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        pending.push_back('{cyc + STOP_LAT, b, stop});
        for (int i = 0; i < 10; i++) begin
            rx_line = bits[i];
            idle(B);
        end
        if (tail_low > 0) begin
            rx_line = 0;
            idle(tail_low);
        end
        rx_line = 1;
    endtask

    task automatic pop_one();
        ready = 1;
        tick();
        ready = 0;
    endtask

    initial begin
        idle(3);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_fe", fe, 0);
        check("rst_ovr", ovr, 0);
        reset = 0;
        idle(5);

        send(8'hA5);
        check("s1_valid", valid, 1);
        check("s1_data", data, 8'hA5);
        check("s1_count", count, 1);
        pop_one();
        check("s1_count_pop", count, 0);

        rx_line = 0;
        idle(4);
        rx_line = 1;
        idle(40);
        check("s2_count", count, 0);
        check("s2_fe", fe_seen, 0);

        send(8'h3C, 0, 48);
        idle(4);
        send(8'h81);
        check("s3_fe_pulses", fe_seen, 1);
        check("s3_data", data, 8'h81);
        check("s3_count", count, 1);
        pop_one();

        for (int i = 0; i <= 8; i++) begin
            send(8'(i));
            idle(2);
        end
        check("s4_count", count, 8);
        check("s4_ovr", ovr, 1);
        for (int i = 0; i < 8; i++) begin
            check("s4_pop", data, i);
            pop_one();
        end
        check("s4_empty", count, 0);
        clr = 1;
        tick();
        clr = 0;
        check("s4_clear", ovr, 0);

        for (int i = 0; i < 8; i++) begin
            send(8'(8'h10 + i));
            idle(2);
        end
        check("s5_full", count, 8);
        fork
            send(8'h5A);
            begin
                idle(STOP_LAT - 1);
                pop_one();
            end
        join
        check("s5_count", count, 8);
        check("s5_ovr", ovr, 0);
        for (int i = 0; i < 8; i++) begin
            check("s5_pop", data, i < 7 ? 8'h11 + i : 8'h5A);
            pop_one();
        end

        send(8'h77);
        idle(2);
        check("s6_pre", count, 1);
        fork
            send(8'hFF);
            begin
                idle(1 + 4 * B + 5);
                reset = 1;
                idle(3);
                check("s6_rst_data", data, 8'h00);
                check("s6_rst_valid", valid, 0);
                check("s6_rst_count", count, 0);
                check("s6_rst_fe", fe, 0);
                check("s6_rst_ovr", ovr, 0);
                reset = 0;
            end
        join
        idle(5);
        send(8'hC3);
        check("s6_data", data, 8'hC3);
        check("s6_count", count, 1);
        pop_one();
        idle(4);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit good;
            int tail, pready;
            b = 8'($urandom);
            good = $urandom_range(0, 7) != 0;
            tail = good ? 0 : $urandom_range(0, 20);
            pready = $urandom_range(0, 3);
            fork
                send(b, good, tail);
                repeat (10 * B + tail) begin
                    ready = $urandom_range(0, 3) < pready;
                    clr = $urandom_range(0, 31) == 0;
                    tick();
                end
            join
            ready = 0;
            clr = 0;
            idle($urandom_range(2, 10));
        end
        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
